core_mem: RTL
=============

Name: core_mem

Overview:
- Memory responder at the far end of the core's instruction-fetch and data ports.
- A single word-organised RAM serves both ports: registered 1-cycle instruction reads and combinational, lane-aligned data reads with byte-enabled writes.
- A loader FSM fills the RAM over a valid/ready stream while holding the core in reset, then releases it.
- Sits beside the core in the top level; `core_rstb` drives the core's `rstb`.

Parameters:
- DEPTH_WORDS, 4096, RAM depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0 for both ports and the loader.
- AUTO_RUN, 0, 1 = after reset go straight to RUN with an all-zero RAM, skipping the loader.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous, active-low reset
- i_addr  in  32  fetch byte address (core next_pc)
- i_data  out  32  fetched word, valid the cycle after i_addr
- d_addr  in  32  data byte address
- d_wr_en  in  1  store strobe
- d_be  in  4  store byte-lane enables, lane n = bits 8n+7:8n
- d_wdata  in  32  store data, already lane-positioned
- d_data  out  32  load data, combinational, right-aligned
- ld_start  in  1  pulse: enter LOAD (from BOOT or RUN)
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted when valid & ready
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader word
- ld_last  in  1  final loader word
- core_rstb  out  1  active-low reset to core
- err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (async, rstb low):
  - State = BOOT, or RUN if AUTO_RUN.
  - core_rstb=0, i_data=0, ld_ready=0, err=0.
  - RAM contents are not reset.
- Address mapping:
  - idx = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR and idx < DEPTH_WORDS.
  - All arithmetic is 32-bit unsigned; wrap below BASE_ADDR counts as out of range.
- FSM states:
  - BOOT: core_rstb=0, ld_ready=0. ld_start -> LOAD.
  - LOAD: core_rstb=0, ld_ready=1.
    - Each accepted beat writes ld_wdata to idx(ld_addr), all 4 lanes.
    - An accepted beat with ld_last -> RUN.
  - RUN:
    - core_rstb goes high on the first clk edge after entering RUN (registered, synchronous deassert).
    - ld_start -> LOAD; core_rstb drops the same cycle via a combinational decode plus register, so it is low in the first LOAD cycle.
  - ld_start while already in LOAD is ignored.
  - ld_last without ld_valid has no effect.
- Instruction port:
  - i_data <= RAM[idx(i_addr)] on every clk edge; 1-cycle latency.
  - Out of range returns 0 and sets err.
  - i_data updates in every state.
  - Write-first: a write to the same word in the same cycle returns the new merged word.
- Data read:
  - d_data = RAM[idx(d_addr)] >> (8*d_addr[1:0]), zero-filled from the top.
  - Combinational, with no intra-cycle store forwarding (old contents until the edge).
  - Out of range returns 0; sets err only when d_wr_en=1 or the state is RUN.
- Data write:
  - In RUN with d_wr_en=1 and in range, update each lane n with d_be[n]=1 from d_wdata at the clk edge.
  - d_be=0 is a no-op.
  - Stores outside RUN are ignored.
  - An out-of-range store is dropped and sets err.
- Loader write: an out-of-range beat is accepted (handshake completes), dropped, and sets err.
- Write-port priority: loader writes happen only in LOAD, core writes only in RUN, so there is never a simultaneous write.
- err: sticky until rstb.
- Reset mid-LOAD: returns to BOOT; partially loaded RAM is kept.

Decomposition:
- Package core_mem_pkg:
  - state enum {BOOT, LOAD, RUN};
  - WORD_W=32, BE_W=4;
  - function for the in-range check and index calculation.
- Sub-module core_mem_ram:
  - DEPTH_WORDS x 32 array;
  - one registered write-first read port;
  - one asynchronous read port;
  - one byte-enabled write port.
- FSM, address checks, lane alignment and err logic stay in core_mem.

Test Plan:
- Reset -> core_rstb=0, i_data=0, ld_ready=0, err=0. ld_start -> ld_ready=1 next cycle.
- LOAD 3 beats (addr 0/4/8 = 32'h00500093/32'h00100113/32'hDEADBEEF, last on 3rd) -> RUN; core_rstb=1 one cycle later. i_addr=4 -> i_data=32'h00100113 next cycle.
- RUN store d_addr=8, d_be=4'b0011, d_wdata=32'h0000_1234 -> word 2 reads 32'hDEAD1234; d_addr=10 -> d_data=32'h0000DEAD; d_addr=11 -> 32'h000000DE.
- Same-cycle store to word 2 (be=4'b1111, 32'hCAFEF00D) and i_addr=8 -> i_data=32'hCAFEF00D; same-cycle d_data still 32'hDEAD1234.
- Store to BASE_ADDR+4*DEPTH_WORDS -> RAM unchanged, err=1 and stays 1; loader beat with ld_valid low -> no write.
- ld_start in RUN -> core_rstb=0 in first LOAD cycle; rstb pulse mid-LOAD -> BOOT, previously loaded words intact.

Source files
------------

// File: rtl/core_mem_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | core_mem_pkg: shared types and address helpers for core_mem   |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
package core_mem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Addresses below the base wrap to huge offsets, so the explicit >= test is required.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && ((off >> 2) < depth);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_ram.sv
`default_nettype none
// +---------------------------------------------------------------+
// | core_mem_ram: word RAM, write-first sync read, async read     |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module core_mem_ram
   import core_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic [AW-1:0]     i_raddr,
   output logic [WORD_W-1:0] o_rdata,
   input  logic [AW-1:0]     i_aaddr,
   output logic [WORD_W-1:0] o_adata,
   input  logic              i_wen,
   input  logic [AW-1:0]     i_waddr,
   input  logic [BE_W-1:0]   i_wbe,
   input  logic [WORD_W-1:0] i_wdata
);

   logic [WORD_W-1:0] r_mem [0:DEPTH_WORDS-1];
   logic [WORD_W-1:0] r_rdata;
   logic [WORD_W-1:0] w_merged;

   always_comb begin
      w_merged = r_mem[i_waddr];
      for (int n = 0; n < BE_W; n++) begin
         if (i_wbe[n]) w_merged[8*n +: 8] = i_wdata[8*n +: 8];
      end
   end

   // Same-word write and fetch in one cycle returns the merged word.
   always_ff @(posedge clk) begin
      if (i_wen) r_mem[i_waddr] <= w_merged;
      r_rdata <= (i_wen && (i_waddr == i_raddr)) ? w_merged : r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
   assign o_adata = r_mem[i_aaddr];

endmodule
`default_nettype wire

// File: rtl/core_mem.sv
`default_nettype none
// +---------------------------------------------------------------+
// | core_mem: shared fetch/data RAM with stream loader and reset  |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module core_mem
   import core_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter bit          AUTO_RUN    = 1'b0
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic [31:0]       i_addr,
   output logic [WORD_W-1:0] i_data,
   input  logic [31:0]       d_addr,
   input  logic              d_wr_en,
   input  logic [BE_W-1:0]   d_be,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_data,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_addr,
   input  logic [WORD_W-1:0] ld_wdata,
   input  logic              ld_last,
   output logic              core_rstb,
   output logic              err
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   state_t r_state;
   logic   r_core_rstb, r_ld_ready, r_err, r_i_ok;

   logic [31:0]       w_i_idx, w_d_idx, w_ld_idx;
   logic              w_i_ok, w_d_ok, w_ld_ok;
   logic              w_ld_fire, w_st, w_wen, w_err_set;
   logic [AW-1:0]     w_waddr;
   logic [BE_W-1:0]   w_wbe;
   logic [WORD_W-1:0] w_wdata, w_rdata, w_adata;
   logic              w_unused;

   assign w_i_idx  = addr_index(i_addr, BASE_ADDR);
   assign w_d_idx  = addr_index(d_addr, BASE_ADDR);
   assign w_ld_idx = addr_index(ld_addr, BASE_ADDR);
   assign w_i_ok   = addr_in_range(i_addr, BASE_ADDR, DEPTH_L);
   assign w_d_ok   = addr_in_range(d_addr, BASE_ADDR, DEPTH_L);
   assign w_ld_ok  = addr_in_range(ld_addr, BASE_ADDR, DEPTH_L);
   assign w_unused = ^{w_i_idx[31:AW], w_d_idx[31:AW], w_ld_idx[31:AW]};

   // Loader and core stores are state-exclusive, so one write port suffices.
   assign w_ld_fire = ld_valid && r_ld_ready;
   assign w_st      = d_wr_en && (r_state == RUN);
   assign w_wen     = (w_ld_fire && w_ld_ok) || (w_st && w_d_ok);
   assign w_waddr   = w_ld_fire ? w_ld_idx[AW-1:0] : w_d_idx[AW-1:0];
   assign w_wbe     = w_ld_fire ? {BE_W{1'b1}} : d_be;
   assign w_wdata   = w_ld_fire ? ld_wdata : d_wdata;

   assign w_err_set = !w_i_ok
                    || (!w_d_ok && (d_wr_en || (r_state == RUN)))
                    || (w_ld_fire && !w_ld_ok);

   core_mem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .i_raddr (w_i_idx[AW-1:0]),
      .o_rdata (w_rdata),
      .i_aaddr (w_d_idx[AW-1:0]),
      .o_adata (w_adata),
      .i_wen   (w_wen),
      .i_waddr (w_waddr),
      .i_wbe   (w_wbe),
      .i_wdata (w_wdata)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state     <= AUTO_RUN ? RUN : BOOT;
         r_core_rstb <= 1'b0;
         r_ld_ready  <= 1'b0;
         r_err       <= 1'b0;
         r_i_ok      <= 1'b0;
      end else begin
         r_i_ok <= w_i_ok;
         if (w_err_set) r_err <= 1'b1;
         case (r_state)
            BOOT: begin
               if (ld_start) begin
                  r_state    <= LOAD;
                  r_ld_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (w_ld_fire && ld_last) begin
                  r_state    <= RUN;
                  r_ld_ready <= 1'b0;
               end
            end
            RUN: begin
               if (ld_start) begin
                  r_state     <= LOAD;
                  r_ld_ready  <= 1'b1;
                  r_core_rstb <= 1'b0;
               end else begin
                  r_core_rstb <= 1'b1;
               end
            end
            default: begin
               r_state    <= BOOT;
               r_ld_ready <= 1'b0;
            end
         endcase
      end
   end

   assign i_data    = r_i_ok ? w_rdata : '0;
   assign d_data    = w_d_ok ? (w_adata >> {d_addr[1:0], 3'b000}) : '0;
   assign ld_ready  = r_ld_ready;
   assign core_rstb = r_core_rstb;
   assign err       = r_err;

endmodule
`default_nettype wire
